rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 34 +++
 rtl/decoder_5x32.sv | 18 +
 rtl/rf_write_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: state encodings,
// width defaults and the two-requester round-robin pick.
package rf_write_arbiter_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 5;
   localparam int REG_CNT_DEF = 1 << ADDR_W_DEF;

   // FSM encodings kept as plain constants so older netlists can match them
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] WRITE = 1'b1;

   typedef struct packed {
      logic g0;
      logic g1;
   } grant_t;

   // Pick a winner among eligible requesters; on a tie the one not granted
   // last wins (last = 1 means requester 1 was granted most recently).
   function automatic grant_t arbitrate(input logic c0, input logic c1,
                                        input logic last);
      grant_t g;
      g = '0;
      if (c0 && c1) begin
         g.g0 = last;
         g.g1 = ~last;
      end else begin
         g.g0 = c0;
         g.g1 = c1;
      end
      return g;
   endfunction

endpackage

// File: rtl/decoder_5x32.sv
// Codebase line decoder: binary select in, one-hot line out
// (5-to-32 at the default width).
module decoder_5x32 #(
   parameter int IN_W = 5
) (
   input  logic [IN_W-1:0]      sel,
   output logic [(2**IN_W)-1:0] dec
);

   // One-hot decode of the select input
   always_comb begin
      // NOTE: assign a default before the indexed write so every bit is
      // driven on every path and no latch is inferred.
      dec      = '0;
      dec[sel] = 1'b1;
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter. A grant captures the winner's
// address/data into output registers for a single WRITE cycle; the register
// file loads on the edge that ends it. Register 0 is hard-wired and is never
// loaded, and a write aimed at it is flagged on zero_wr instead.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic [ADDR_W-1:0]     addr0,
   input  logic [DATA_W-1:0]     data0,
   input  logic                  req1,
   input  logic [ADDR_W-1:0]     addr1,
   input  logic [DATA_W-1:0]     data1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic [ADDR_W-1:0]     waddr,
   output logic [DATA_W-1:0]     wdata,
   output logic [(2**ADDR_W)-1:0] load,
   output logic                  zero_wr,
   output logic                  busy
);

   localparam int REG_CNT = 2 ** ADDR_W;

   logic [0:0]         state;
   logic               last;
   logic               cand0;
   logic               cand1;
   grant_t             win;
   logic               grant_any;
   logic [ADDR_W-1:0]  addr_nxt;
   logic [DATA_W-1:0]  data_nxt;
   logic [REG_CNT-1:0] dec_out;
   logic               addr_is_zero;

   // Eligibility and winner selection; the requester granted this cycle is
   // masked at the edge ending WRITE since it has not yet dropped its request.
   always_comb begin
      cand0        = req0 & ~((state == WRITE) & gnt0);
      cand1        = req1 & ~((state == WRITE) & gnt1);
      win          = arbitrate(cand0, cand1, last);
      grant_any    = win.g0 | win.g1;
      addr_nxt     = win.g1 ? addr1 : addr0;
      data_nxt     = win.g1 ? data1 : data0;
      addr_is_zero = (addr_nxt == '0);
   end

   decoder_5x32 #(
      .IN_W (ADDR_W)
   ) u_dec (
      .sel (addr_nxt),
      .dec (dec_out)
   );

   // FSM, round-robin pointer, capture registers and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         last    <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
         load    <= '0;
         zero_wr <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples
         // the pre-edge values, independent of statement order.
         state   <= grant_any ? WRITE : IDLE;
         gnt0    <= win.g0;
         gnt1    <= win.g1;
         zero_wr <= grant_any & addr_is_zero;
         load    <= (grant_any && !addr_is_zero) ? (dec_out & ~REG_CNT'(1)) : '0;
         if (grant_any) begin
            waddr <= addr_nxt;
            wdata <= data_nxt;
            last  <= win.g1;
         end
      end
   end

   assign busy = (state == WRITE);

endmodule
